// File: rtl/bundle_issuer.sv
// Two-entry bundle queue that presents the oldest VLIW bundle to all functional
// units in lockstep and retires it only when every unit can accept it.
module bundle_issuer #(
    parameter int          NUM_FU = 4,
    parameter logic [31:0] NOP    = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [32*NUM_FU-1:0] fetch_bundle,
    input  logic [63:0]          fetch_addr,
    input  logic                 flush,
    input  logic                 hold,
    input  logic [NUM_FU-1:0]    fu_busy,
    output logic [32*NUM_FU-1:0] instruction,
    output logic [63:0]          bundleAddr,
    output logic [NUM_FU-1:0]    do_stall,
    output logic                 issue_fire,
    output logic [63:0]          issued_count
);
    localparam int BW = 32 * NUM_FU;

    logic [1:0]    count;
    logic [BW-1:0] headBundle, tailBundle;
    logic [63:0]   headAddr, tailAddr;
    logic          push, pop;

    // fetch_ready never looks at fu_busy or the pop, so a full queue stays closed.
    assign fetch_ready = rst_n & ~flush & (count < 2'd2);
    assign push        = fetch_valid & fetch_ready;
    assign issue_fire  = rst_n & (count != 2'd0) & ~hold & ~|fu_busy & ~flush;
    assign pop         = issue_fire;

    assign instruction = (count != 2'd0) ? headBundle : {NUM_FU{NOP}};
    assign bundleAddr  = headAddr;
    assign do_stall    = {NUM_FU{~issue_fire}};

    // Control state; headAddr is reset too because it is visible while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= 2'd0;
            issued_count <= 64'd0;
            headAddr     <= 64'd0;
        end else begin
            if (flush) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
            if (issue_fire) begin
                issued_count <= issued_count + 64'd1;
            end
            // Head address is never cleared on pop, so it keeps the last head shown.
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                headAddr <= fetch_addr;
            end else if (pop && count == 2'd2) begin
                headAddr <= tailAddr;
            end
        end
    end

    // Bundle payload storage; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
            headBundle <= fetch_bundle;
        end else if (pop && count == 2'd2) begin
            headBundle <= tailBundle;
        end
        if (push && count == 2'd1 && !pop) begin
            tailBundle <= fetch_bundle;
            tailAddr   <= fetch_addr;
        end
    end

endmodule

// File: tb/tb_bundle_issuer.sv
// Randomised and directed bench for bundle_issuer against a queue-based model
// of the issue rules.
module tb_bundle_issuer;
    localparam int          NUM_FU = 4;
    localparam int          BW     = 32 * NUM_FU;
    localparam logic [31:0] NOPV   = 32'hDEAD_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [BW-1:0]     fetch_bundle;
    logic [63:0]       fetch_addr;
    logic              flush;
    logic              hold;
    logic [NUM_FU-1:0] fu_busy;
    logic [BW-1:0]     instruction;
    logic [63:0]       bundleAddr;
    logic [NUM_FU-1:0] do_stall;
    logic              issue_fire;
    logic [63:0]       issued_count;

    bundle_issuer #(.NUM_FU(NUM_FU), .NOP(NOPV)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_bundle(fetch_bundle), .fetch_addr(fetch_addr), .flush(flush), .hold(hold),
        .fu_busy(fu_busy), .instruction(instruction), .bundleAddr(bundleAddr),
        .do_stall(do_stall), .issue_fire(issue_fire), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] b;
        logic [63:0]   a;
    } entry_t;

    entry_t      q[$];
    logic [63:0] mCount;
    logic [63:0] mLastAddr;
    int          errs   = 0;
    int          checks = 0;
    int          fires  = 0;

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] rndBundle();
        logic [BW-1:0] r;
        for (int i = 0; i < NUM_FU; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Drive one cycle at the falling edge, check outputs, then advance the model.
    task automatic step(input logic v, input logic [BW-1:0] b, input logic [63:0] a,
                        input logic fl, input logic h, input logic [NUM_FU-1:0] bz,
                        input logic rn);
        logic          eReady, eFire;
        logic [BW-1:0] eInstr;
        logic [63:0]   eAddr;
        entry_t        e;
        fetch_valid = v; fetch_bundle = b; fetch_addr = a;
        flush = fl; hold = h; fu_busy = bz; rst_n = rn;
        #1;
        eReady = rn && !fl && (q.size() < 2);
        eFire  = rn && (q.size() != 0) && !h && (bz == '0) && !fl;
        eInstr = (q.size() != 0) ? q[0].b : {NUM_FU{NOPV}};
        eAddr  = (q.size() != 0) ? q[0].a : mLastAddr;
        checkVal("fetch_ready", 256'(fetch_ready), 256'(eReady));
        checkVal("issue_fire", 256'(issue_fire), 256'(eFire));
        checkVal("do_stall", 256'(do_stall), 256'(eFire ? {NUM_FU{1'b0}} : {NUM_FU{1'b1}}));
        checkVal("instruction", 256'(instruction), 256'(eInstr));
        checkVal("bundleAddr", 256'(bundleAddr), 256'(eAddr));
        checkVal("issued_count", 256'(issued_count), 256'(mCount));
        if (!rn) begin
            q.delete(); mCount = 0; mLastAddr = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (eFire) begin
                void'(q.pop_front());
                mCount = mCount + 64'd1;
                fires++;
            end
            if (v && eReady) begin
                e.b = b; e.a = a;
                q.push_back(e);
            end
            if (q.size() != 0) mLastAddr = q[0].a;
        end
        @(negedge clk);
    endtask

    logic [BW-1:0] bA, bB, bC, bD, bE, bF;

    initial begin
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_bundle = '0; fetch_addr = '0;
        flush = 1'b0; hold = 1'b0; fu_busy = '0;
        mCount = 0; mLastAddr = 0;
        bA = rndBundle(); bB = rndBundle(); bC = rndBundle();
        bD = rndBundle(); bE = rndBundle(); bF = rndBundle();
        @(posedge clk); @(negedge clk);
        step(0, '0, '0, 0, 0, '0, 0);

        // A then B back to back, each issuing one cycle after acceptance.
        step(1, bA, 64'h1000, 0, 0, '0, 1);
        step(1, bB, 64'h1010, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, '0, 1);
        checkVal("count_after_AB", 256'(issued_count), 256'(64'd2));

        // One busy unit for three cycles with A at the head.
        step(1, bA, 64'h2000, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, 0, 4'b0100, 1);
        step(0, '0, '0, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, '0, 1);

        // Hold while offering three bundles; the third is refused, then re-offered.
        step(1, bC, 64'h3000, 0, 1, '0, 1);
        step(1, bD, 64'h3010, 0, 1, '0, 1);
        step(1, bE, 64'h3020, 0, 1, '0, 1);
        step(1, bE, 64'h3020, 0, 0, '0, 1);
        step(1, bE, 64'h3020, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, '0, 1);

        // Flush with a full queue and a bundle on offer.
        step(1, bA, 64'h4000, 0, 1, '0, 1);
        step(1, bB, 64'h4010, 0, 1, '0, 1);
        step(1, bF, 64'h4020, 1, 0, '0, 1);
        step(0, '0, '0, 0, 0, '0, 1);
        checkVal("flush_nop", 256'(instruction), 256'({NUM_FU{NOPV}}));

        // Counter wrap from all ones.
        force dut.issued_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.issued_count;
        mCount = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        step(1, bC, 64'h5000, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, '0, 1);
        step(0, '0, '0, 0, 0, '0, 1);
        checkVal("wrap_zero", 256'(issued_count), 256'(64'd0));

        // Reset mid-stall with a full queue.
        step(1, bD, 64'h6000, 0, 0, 4'b0001, 1);
        step(1, bE, 64'h6010, 0, 0, 4'b0001, 1);
        step(0, '0, '0, 0, 0, 4'b0001, 1);
        step(1, bF, 64'h6020, 0, 0, '0, 0);
        step(0, '0, '0, 0, 0, '0, 1);
        checkVal("rst_addr", 256'(bundleAddr), 256'(64'd0));

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), rndBundle(), {$urandom, $urandom},
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                 (($urandom_range(0, 3) == 0) ? NUM_FU'($urandom) : '0),
                 ($urandom_range(0, 49) != 0));
        end
        if (fires < 50) begin
            errs++;
            $display("FAIL random_issue_activity: got %0d issues expected at least 50", fires);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
